// File: rtl/muldiv_pkg.sv
// Shared encodings and op predicates for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULTU = 3'd0, OP_MULT = 3'd1, OP_MADDU = 3'd2, OP_MADD = 3'd3,
    OP_MSUBU = 3'd4, OP_MSUB = 3'd5, OP_DIVU  = 3'd6, OP_DIV  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  } state_e;

  localparam int OP_SIGNED_BIT = 0;

  function automatic logic is_div(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return op[2] ^ op[1];
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return op[2] & ~op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvs_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  // Partial remainder is W+1 bits once the next bit is shifted in.
  logic [W:0] sh, diff;
  logic       unused_diff_msb;

  assign sh    = {rem_i, bit_i};
  assign diff  = sh - {1'b0, dvs_i};
  assign q_o   = (sh >= {1'b0, dvs_i});
  assign rem_o = q_o ? diff[W-1:0] : sh[W-1:0];
  assign unused_diff_msb = diff[W];

endmodule

// File: rtl/muldiv_iter.sv
// Sequential MULT/MADD/MSUB/DIV engine behind a start/done handshake.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int W        = 32,
  parameter int MUL_BITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [2:0]     op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [2*W-1:0] acc_i,
  input  logic           cancel_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [W-1:0]   hi_o,
  output logic [W-1:0]   lo_o,
  output logic           dbz_o
);

  if (MUL_BITS < 1 || (W % MUL_BITS) != 0) begin : g_bad_mul_bits
    $error("MUL_BITS must divide W");
  end

  localparam int CW      = $clog2(W + 1);
  localparam int MUL_CYC = W / MUL_BITS;

  state_e         state, state_nx;
  op_e            op_q;
  logic [2*W-1:0] acc_q, mcand, prod, pp, p_s, fix_res;
  logic [W-1:0]   mplier, dvs, dvd, rem, rem_nx, q_s, r_s, a_abs, b_abs;
  logic           neg, rneg, q_bit, sgn, accept, dbz_start;
  logic [CW-1:0]  cnt;

  assign sgn       = op_i[OP_SIGNED_BIT];
  assign a_abs     = (sgn && a_i[W-1]) ? -a_i : a_i;
  assign b_abs     = (sgn && b_i[W-1]) ? -b_i : b_i;
  assign accept    = (state == S_IDLE || state == S_DONE) && start_i && !cancel_i;
  assign dbz_start = is_div(op_i) && (b_i == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cancel_i) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (!start_i)          state_nx = S_IDLE;
          else if (!is_div(op_i)) state_nx = S_MUL;
          else if (dbz_start)    state_nx = S_DONE;
          else                   state_nx = S_DIV;
        end
        S_MUL, S_DIV: if (cnt == '0) state_nx = S_FIX;
        S_FIX:        state_nx = S_DONE;
        default:      state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    done_o = (state == S_DONE);
  end

  // Shift-add: MUL_BITS multiplier bits against a left-shifting multiplicand.
  assign pp = mcand * {{(2*W-MUL_BITS){1'b0}}, mplier[MUL_BITS-1:0]};

  div_step #(.W(W)) u_step (
    .rem_i (rem),
    .dvs_i (dvs),
    .bit_i (dvd[W-1]),
    .rem_o (rem_nx),
    .q_o   (q_bit)
  );

  assign p_s = neg  ? -prod : prod;
  assign q_s = neg  ? -dvd  : dvd;
  assign r_s = rneg ? -rem  : rem;

  always_comb begin
    fix_res = p_s;
    if (is_div(op_q))      fix_res = {r_s, q_s};
    else if (is_acc(op_q)) fix_res = is_sub(op_q) ? acc_q - p_s : acc_q + p_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_MULTU; acc_q <= '0; neg <= 1'b0; rneg <= 1'b0;
      mcand <= '0; mplier <= '0; prod <= '0;
      dvd <= '0; dvs <= '0; rem <= '0; cnt <= '0;
      hi_o <= '0; lo_o <= '0; dbz_o <= 1'b0;
    end else if (accept) begin
      op_q   <= op_e'(op_i);
      acc_q  <= acc_i;
      neg    <= sgn & (a_i[W-1] ^ b_i[W-1]);
      rneg   <= sgn & a_i[W-1];
      mcand  <= {{W{1'b0}}, a_abs};
      mplier <= b_abs;
      prod   <= '0;
      dvd    <= a_abs;
      dvs    <= b_abs;
      rem    <= '0;
      cnt    <= is_div(op_i) ? CW'(W - 1) : CW'(MUL_CYC - 1);
      if (dbz_start) begin
        hi_o  <= a_i;
        lo_o  <= '1;
        dbz_o <= 1'b1;
      end
    end else if (!cancel_i) begin
      case (state)
        S_MUL: begin
          prod   <= prod + pp;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt - 1'b1;
        end
        S_DIV: begin
          rem <= rem_nx;
          dvd <= {dvd[W-2:0], q_bit};
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          {hi_o, lo_o} <= fix_res;
          dbz_o        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed and random checks of muldiv_iter for MUL_BITS = 1, 2, 4, 8 against an arithmetic model.
module tb_muldiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [63:0] acc;
  logic        busy[4], done[4], dbz[4];
  logic [31:0] hi[4], lo[4];

  int checks = 0;
  int errors = 0;

  // Instance g runs MUL_BITS = 2**g; instance 1 is the default configuration.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    muldiv_iter #(.W(32), .MUL_BITS(1 << g)) dut (
      .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .acc_i(acc), .cancel_i(cancel), .busy_o(busy[g]), .done_o(done[g]),
      .hi_o(hi[g]), .lo_o(lo[g]), .dbz_o(dbz[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] ia, ib,
                                input logic [63:0] iacc,
                                output logic [31:0] ehi, elo, output logic edbz);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    edbz = 1'b0;
    if (o >= 3'd6) begin
      if (ib == 0) begin
        ehi = ia; elo = 32'hFFFF_FFFF; edbz = 1'b1;
      end else if (o[0]) begin
        q = sa / sb; r = sa % sb;
        ehi = r[31:0]; elo = q[31:0];
      end else begin
        ehi = ia % ib; elo = ia / ib;
      end
    end else begin
      if (o[0]) p = sa * sb;
      else      p = {32'h0, ia} * {32'h0, ib};
      if (o == 3'd2 || o == 3'd3)      p = iacc + p;
      else if (o == 3'd4 || o == 3'd5) p = iacc - p;
      {ehi, elo} = p;
    end
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [31:0] ib, input int mb);
    if (o >= 3'd6) return (ib == 0) ? 1 : 34;
    return 32 / mb + 2;
  endfunction

  // Runs one op on all instances; optionally pulses start (a divide-by-zero) in cycle pulse.
  task automatic run_op(input logic [2:0] o, input logic [31:0] ia, ib,
                        input logic [63:0] iacc, input int pulse);
    logic [31:0] ehi, elo;
    logic        edbz;
    int          seen[4];
    model(o, ia, ib, iacc, ehi, elo, edbz);
    for (int i = 0; i < 4; i++) seen[i] = -1;
    @(negedge clk);
    op = o; a = ia; b = ib; acc = iacc; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == pulse);
      if (k == pulse) begin op = 3'd6; b = 32'h0; end
      acc = ~iacc;
      if (k == 1) chk($sformatf("busy_c1_op%0d", o), 64'(busy[1]), 64'(lat(o, ib, 2) != 1));
      for (int i = 0; i < 4; i++) begin
        if (done[i] && seen[i] < 0) begin
          seen[i] = k;
          chk($sformatf("hi_op%0d_mb%0d", o, 1 << i), 64'(hi[i]), 64'(ehi));
          chk($sformatf("lo_op%0d_mb%0d", o, 1 << i), 64'(lo[i]), 64'(elo));
          chk($sformatf("dbz_op%0d_mb%0d", o, 1 << i), 64'(dbz[i]), 64'(edbz));
        end
      end
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("done_cyc_op%0d_mb%0d", o, 1 << i), 64'(seen[i]), 64'(lat(o, ib, 1 << i)));
  endtask

  task automatic wait_main(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done[1]) begin cyc = k; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0; cancel = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int c, seen_done;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0; acc = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy[1]), 64'(0));
    chk("rst_done", 64'(done[1]), 64'(0));
    chk("rst_hi",   64'(hi[1]),   64'(0));
    chk("rst_lo",   64'(lo[1]),   64'(0));
    chk("rst_dbz",  64'(dbz[1]),  64'(0));
    rst = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 64'h0, 0);
    run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_FFFF_FFFF, 0);
    run_op(3'd5, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_FFFF_FFFF, 0);
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 64'h0, 0);
    run_op(3'd6, 32'd7, 32'd2, 64'h0, 0);
    run_op(3'd6, 32'h0000_1234, 32'h0, 64'h0, 0);
    run_op(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 0);
    run_op(3'd1, 32'd5, 32'hFFFF_FFF9, 64'h0, 5);
    run_op(3'd6, 32'd100, 32'd7, 64'h0, 0);

    // Cancel in cycle 5 of a DIV, with a competing start that must be dropped.
    @(negedge clk); op = 3'd7; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); start = 1'b0;
      if (k == 5) begin cancel = 1'b1; start = 1'b1; op = 3'd0; end
    end
    @(negedge clk); cancel = 1'b0; start = 1'b0;
    chk("cancel_busy", 64'(busy[1]), 64'(0));
    seen_done = 0;
    repeat (40) begin @(negedge clk); if (done[1]) seen_done = 1; end
    chk("cancel_nodone", 64'(seen_done), 64'(0));
    chk("cancel_hi", 64'(hi[1]), 64'(2));
    chk("cancel_lo", 64'(lo[1]), 64'(14));

    // Back-to-back: a start in the DONE cycle is taken without a bubble.
    do_reset();
    @(negedge clk); op = 3'd0; a = 32'd9; b = 32'd11; acc = '0; start = 1'b1;
    wait_main(c);
    chk("b2b_first_cyc", 64'(c), 64'(18));
    chk("b2b_first_lo", 64'(lo[1]), 64'(99));
    op = 3'd6; a = 32'd100; b = 32'd7; start = 1'b1;
    wait_main(c);
    chk("b2b_second_cyc", 64'(c), 64'(34));
    chk("b2b_second_hi", 64'(hi[1]), 64'(2));
    chk("b2b_second_lo", 64'(lo[1]), 64'(14));

    // Reset mid-DIV clears every output on the next edge.
    @(negedge clk); op = 3'd6; a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (5) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy[1]), 64'(0));
    chk("midrst_done", 64'(done[1]), 64'(0));
    chk("midrst_hi",   64'(hi[1]),   64'(0));
    chk("midrst_lo",   64'(lo[1]),   64'(0));
    chk("midrst_dbz",  64'(dbz[1]),  64'(0));
    rst = 1'b0;

    do_reset();
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'h0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, {$urandom, $urandom}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply / multiply-accumulate / divide unit for the execute stage. It replaces the execute stage's single-cycle multiplier and two-cycle accumulate scheme with one sequential engine behind a start/done handshake. It covers MULT/MULTU, MADD/MADDU, MSUB/MSUBU and DIV/DIVU. The execute stage holds its stall request while `busy_o` is high and writes `{hi_o, lo_o}` to HI/LO on `done_o`.

## Interface
- `W`, 32: operand width; HI/LO are each `W` bits.
- `MUL_BITS`, 2: multiplier bits retired per cycle; must divide `W`. Elaboration fails otherwise.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start_i`  in  1: request; sampled only when `busy_o`=0.
- `op_i`  in  3: 0 MULTU, 1 MULT, 2 MADDU, 3 MADD, 4 MSUBU, 5 MSUB, 6 DIVU, 7 DIV; bit0 = signed.
- `a_i`  in  W: rs (multiplicand / dividend).
- `b_i`  in  W: rt (multiplier / divisor).
- `acc_i`  in  2W: current `{HI,LO}` with forwarding already applied; used by MADD/MSUB.
- `cancel_i`  in  1: flush from exception or branch; aborts the operation.
- `busy_o`  out  1: operation in progress.
- `done_o`  out  1: one-cycle pulse; results valid.
- `hi_o`, `lo_o`  out  W each: result; held until the next accepted start.
- `dbz_o`  out  1: divide by zero; valid with `done_o` and held with the results.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE or DONE with `start_i`=1 and `cancel_i`=0 does the following:
  - Latch `op_i` and `acc_i`.
  - For signed ops, latch |a| and |b|, plus `neg` = a[W-1]^b[W-1] and `rneg` = a[W-1].
  - Load the iteration counter.
  - Go to MUL (op<6) or DIV (op>=6).
- DIV with b=0 goes from IDLE directly to DONE with `lo_o` = all ones, `hi_o` = a_i, `dbz_o`=1.
- MUL: shift-add over `MUL_BITS` multiplier bits per cycle for `W/MUL_BITS` cycles. Arithmetic is 2W-bit unsigned. Then FIX.
- DIV: restoring division, one quotient bit per cycle for `W` cycles. The remainder is W+1 bits. Then FIX.
- FIX (one cycle):
  - If signed and `neg`, negate the product or quotient. If signed and `rneg`, negate the remainder.
  - MADD*: result = acc + product. MSUB*: result = acc − product. Both are mod 2^(2W), with no overflow flag.
  - Go to DONE.
- DONE: `done_o`=1 for that cycle only. The next state is IDLE, or a new op if `start_i` is high.
- Divide results: HI = remainder, LO = quotient. Remainder takes the sign of the dividend.
- Signed −2^(W−1) ÷ −1 gives LO = 0x8000_0000 and HI = 0 (W=32). No special case is needed.
- `cancel_i` in any state: next state IDLE, no `done_o`, outputs keep their prior values. `cancel_i` beats `start_i` in the same cycle.
- `start_i` while busy (MUL/DIV/FIX) is ignored.
- `rst` mid-operation: IDLE on the next edge.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `hi_o`=`lo_o`=0, `dbz_o`=0, state IDLE.
- `busy_o` = state ∈ {MUL, DIV, FIX}. It is registered and rises the cycle after start is accepted.
- Count the start cycle as cycle 0. `done_o` is high in:
  - Multiply class: cycle W/MUL_BITS+2. W=32, MUL_BITS=2 gives cycle 18.
  - Divide: cycle W+2, i.e. 34.
  - Divide by zero: cycle 1.
- `hi_o`/`lo_o`/`dbz_o` update on the edge entering DONE and are stable from the `done_o` cycle onward.
- Back-to-back: a start in the DONE cycle is accepted, so there is no idle bubble.
- `acc_i` is sampled only at the accept edge. A later change of HI/LO does not affect the result.

## Structure
- Shared package `muldiv_pkg`:
  - `op_e` encoding (values above).
  - `state_e`.
  - Constant `OP_SIGNED_BIT` = 0.
  - Predicates `is_div(op)` and `is_acc(op)`.
- One sub-module, `div_step`: combinational single restoring step. Inputs: remainder, divisor, next dividend bit. Outputs: next remainder, quotient bit.
- Multiplier partial-product logic stays inline.

## Test plan
- MULT, a=0xFFFF_FFFE (−2), b=3 → `done_o` in cycle 18; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- MADDU, acc=0x0000_0001_FFFF_FFFF, a=b=0x0001_0000 → hi=0x0000_0002, lo=0xFFFF_FFFF. MSUB with the same operands (signed, acc as before) → hi=0x0000_0000, lo=0xFFFF_FFFF.
- DIV, a=−7, b=2 → done in cycle 34; lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). DIVU, a=7, b=2 → lo=3, hi=1.
- DIVU with b=0, a=0x1234 → `done_o` in cycle 1, `dbz_o`=1, lo=0xFFFF_FFFF, hi=0x1234.
- `cancel_i` in cycle 5 of a DIV → IDLE next cycle, no `done_o`, prior results unchanged. A `start_i` raised together with `cancel_i` is dropped.
- Further cases:
  - `start_i` pulsed mid-MUL is ignored.
  - A start in the DONE cycle is accepted with no bubble.
  - `rst` asserted mid-DIV → all outputs 0 next cycle.
  - Parameter sweep MUL_BITS ∈ {1, 2, 4, 8} with random operands against a reference model.
